// File: rtl/commit_if.sv
// ROB head row handed to the commit unit: two slots of finished uops plus the row handshake.
interface commit_if #(
    parameter int unsigned PRF_W = 6
) ();
    logic             rob_valid;
    logic             rob_ready;
    logic             s0_valid;
    logic             s1_valid;
    logic             s0_wr_en;
    logic             s1_wr_en;
    logic [4:0]       s0_arch_rd;
    logic [4:0]       s1_arch_rd;
    logic [PRF_W-1:0] s0_phy_rd;
    logic [PRF_W-1:0] s1_phy_rd;
    logic [PRF_W-1:0] s0_old_phy_rd;
    logic [PRF_W-1:0] s1_old_phy_rd;
    logic             s0_is_br;
    logic             s1_is_br;
    logic             s0_taken;
    logic             s1_taken;
    logic             s0_pred_taken;
    logic             s1_pred_taken;
    logic [31:0]      s0_target;
    logic [31:0]      s1_target;
    logic [31:0]      s0_pred_target;
    logic [31:0]      s1_pred_target;
    logic [31:0]      s0_pc;
    logic [31:0]      s1_pc;

    modport master (
        output rob_valid, s0_valid, s1_valid, s0_wr_en, s1_wr_en, s0_arch_rd, s1_arch_rd,
               s0_phy_rd, s1_phy_rd, s0_old_phy_rd, s1_old_phy_rd, s0_is_br, s1_is_br,
               s0_taken, s1_taken, s0_pred_taken, s1_pred_taken, s0_target, s1_target,
               s0_pred_target, s1_pred_target, s0_pc, s1_pc,
        input  rob_ready
    );

    modport slave (
        input  rob_valid, s0_valid, s1_valid, s0_wr_en, s1_wr_en, s0_arch_rd, s1_arch_rd,
               s0_phy_rd, s1_phy_rd, s0_old_phy_rd, s1_old_phy_rd, s0_is_br, s1_is_br,
               s0_taken, s1_taken, s0_pred_taken, s1_pred_taken, s0_target, s1_target,
               s0_pred_target, s1_pred_target, s0_pc, s1_pc,
        output rob_ready
    );
endinterface

// File: rtl/commit_unit.sv
// Two-wide in-order commit: ARAT update, free-list release, branch-mispredict flush with delay slot.
// Optional performance counters enabled by defining COMMIT_PERF_CNT_EN.
module commit_unit #(
    parameter int unsigned PRF_W = 6,
    parameter int unsigned ARF_N = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_flush,
    commit_if.slave                rob,
    output logic                   fl_rel0_valid,
    output logic [PRF_W-1:0]       fl_rel0_reg,
    output logic                   fl_rel1_valid,
    output logic [PRF_W-1:0]       fl_rel1_reg,
    output logic [ARF_N*PRF_W-1:0] arat_snapshot,
    output logic                   flush_req,
    output logic [31:0]            redirect_pc,
    output logic [31:0]            perf_commit_cnt,
    output logic [31:0]            perf_mispred_cnt
);
    typedef enum logic [1:0] {StRun, StWaitDs, StFlush} state_e;

    state_e           state_q, state_d;
    logic [PRF_W-1:0] arat_q [ARF_N];
    logic [PRF_W-1:0] arat_d [ARF_N];
    logic             rel0_valid_q, rel0_valid_d, rel1_valid_q, rel1_valid_d;
    logic [PRF_W-1:0] rel0_reg_q, rel0_reg_d, rel1_reg_q, rel1_reg_d;
    logic             flush_req_q, flush_req_d;
    logic [31:0]      redirect_q, redirect_d;
    logic             ready, fire, mp0, mp1, c0, c1, w0, w1, trigger;

    assign ready         = (state_q != StFlush) && !ctrl_flush;
    assign fire          = rob.rob_valid && ready;
    assign rob.rob_ready = ready;

    assign mp0 = rob.s0_valid && rob.s0_is_br && ((rob.s0_taken != rob.s0_pred_taken) ||
                 (rob.s0_taken && (rob.s0_target != rob.s0_pred_target)));
    assign mp1 = rob.s1_valid && rob.s1_is_br && ((rob.s1_taken != rob.s1_pred_taken) ||
                 (rob.s1_taken && (rob.s1_target != rob.s1_pred_target)));

    always_comb begin
        state_d    = state_q;
        redirect_d = redirect_q;
        c0         = 1'b0;
        c1         = 1'b0;
        trigger    = 1'b0;
        if (ctrl_flush) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (fire) begin
                        c0 = rob.s0_valid;
                        c1 = rob.s1_valid;
                        // Slot0 takes priority; a valid slot1 is its delay slot.
                        if (mp0) begin
                            trigger    = 1'b1;
                            redirect_d = rob.s0_taken ? rob.s0_target : rob.s0_pc + 32'd8;
                            state_d    = rob.s1_valid ? StFlush : StWaitDs;
                        end else if (mp1) begin
                            trigger    = 1'b1;
                            redirect_d = rob.s1_taken ? rob.s1_target : rob.s1_pc + 32'd8;
                            state_d    = StWaitDs;
                        end
                    end
                end
                StWaitDs: begin
                    if (fire) begin
                        c0      = rob.s0_valid;
                        c1      = rob.s1_valid && !rob.s0_valid;
                        state_d = StFlush;
                    end
                end
                StFlush: state_d = StRun;
                default: state_d = StRun;
            endcase
        end
        flush_req_d = (state_d == StFlush);
    end

    always_comb begin
        w0 = c0 && rob.s0_wr_en && (rob.s0_arch_rd != 5'd0);
        w1 = c1 && rob.s1_wr_en && (rob.s1_arch_rd != 5'd0);
        for (int i = 0; i < int'(ARF_N); i++) begin
            arat_d[i] = arat_q[i];
        end
        // Slot1 is younger, so its write lands last and wins on a shared arch_rd.
        if (w0 && (32'(rob.s0_arch_rd) < ARF_N)) arat_d[rob.s0_arch_rd] = rob.s0_phy_rd;
        if (w1 && (32'(rob.s1_arch_rd) < ARF_N)) arat_d[rob.s1_arch_rd] = rob.s1_phy_rd;
        rel0_valid_d = w0;
        rel0_reg_d   = rob.s0_old_phy_rd;
        rel1_valid_d = w1;
        rel1_reg_d   = rob.s1_old_phy_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            rel0_valid_q <= 1'b0;
            rel0_reg_q   <= '0;
            rel1_valid_q <= 1'b0;
            rel1_reg_q   <= '0;
            flush_req_q  <= 1'b0;
            redirect_q   <= '0;
            for (int i = 0; i < int'(ARF_N); i++) begin
                arat_q[i] <= PRF_W'(i);
            end
        end else begin
            state_q      <= state_d;
            rel0_valid_q <= rel0_valid_d;
            rel0_reg_q   <= rel0_reg_d;
            rel1_valid_q <= rel1_valid_d;
            rel1_reg_q   <= rel1_reg_d;
            flush_req_q  <= flush_req_d;
            redirect_q   <= redirect_d;
            for (int i = 0; i < int'(ARF_N); i++) begin
                arat_q[i] <= arat_d[i];
            end
        end
    end

    always_comb begin
        arat_snapshot = '0;
        for (int i = 0; i < int'(ARF_N); i++) begin
            arat_snapshot[i*PRF_W +: PRF_W] = arat_q[i];
        end
    end

    assign fl_rel0_valid = rel0_valid_q;
    assign fl_rel0_reg   = rel0_reg_q;
    assign fl_rel1_valid = rel1_valid_q;
    assign fl_rel1_reg   = rel1_reg_q;
    assign flush_req     = flush_req_q;
    assign redirect_pc   = redirect_q;

`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] commit_cnt_q, commit_cnt_d, mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        commit_cnt_d  = commit_cnt_q + 32'(c0) + 32'(c1);
        mispred_cnt_d = mispred_cnt_q + 32'(trigger);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            commit_cnt_q  <= commit_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign perf_commit_cnt  = commit_cnt_q;
    assign perf_mispred_cnt = mispred_cnt_q;
`else
    assign perf_commit_cnt  = 32'd0;
    assign perf_mispred_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: spec-level model checked every cycle plus literal spot checks.
module tb_commit_unit;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst;
    logic ctrl_flush;
    logic fl_rel0_valid, fl_rel1_valid, flush_req;
    logic [PW-1:0] fl_rel0_reg, fl_rel1_reg;
    logic [32*PW-1:0] arat_snapshot;
    logic [31:0] redirect_pc, perf_commit_cnt, perf_mispred_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    commit_if #(.PRF_W(PW)) bus ();

    commit_unit #(.PRF_W(PW), .ARF_N(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .ctrl_flush       (ctrl_flush),
        .rob              (bus),
        .fl_rel0_valid    (fl_rel0_valid),
        .fl_rel0_reg      (fl_rel0_reg),
        .fl_rel1_valid    (fl_rel1_valid),
        .fl_rel1_reg      (fl_rel1_reg),
        .arat_snapshot    (arat_snapshot),
        .flush_req        (flush_req),
        .redirect_pc      (redirect_pc),
        .perf_commit_cnt  (perf_commit_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [PW-1:0] m_arat [32];
    bit            m_started = 0;
    bit            m_pending_ds, m_flush, m_rel0v, m_rel1v;
    logic [PW-1:0] m_rel0r, m_rel1r;
    logic [31:0]   m_redir, m_cc, m_mc;

    function automatic bit mispredicts(input bit br, input bit t, input bit pt,
                                       input logic [31:0] tg, input logic [31:0] ptg);
        return br && ((t != pt) || (t && (tg != ptg)));
    endfunction

    always @(posedge clk) begin : model
        bit take0, take1, bad0, bad1, next_flush;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_arat[i] = PW'(i);
            m_pending_ds = 0; m_flush = 0; m_rel0v = 0; m_rel1v = 0;
            m_rel0r = '0; m_rel1r = '0; m_redir = 0; m_cc = 0; m_mc = 0;
            m_started = 1;
        end else begin
            next_flush = 0;
            m_rel0v = 0;
            m_rel1v = 0;
            if (ctrl_flush) begin
                m_pending_ds = 0;
            end else if (bus.rob_valid && !m_flush) begin
                take0 = bus.s0_valid;
                take1 = bus.s1_valid;
                if (m_pending_ds) begin
                    take1 = bus.s1_valid && !bus.s0_valid;
                    m_pending_ds = 0;
                    next_flush = 1;
                end else begin
                    bad0 = bus.s0_valid && mispredicts(bus.s0_is_br, bus.s0_taken,
                           bus.s0_pred_taken, bus.s0_target, bus.s0_pred_target);
                    bad1 = bus.s1_valid && mispredicts(bus.s1_is_br, bus.s1_taken,
                           bus.s1_pred_taken, bus.s1_target, bus.s1_pred_target);
                    if (bad0) begin
                        m_redir = bus.s0_taken ? bus.s0_target : bus.s0_pc + 8;
                        if (bus.s1_valid) next_flush = 1; else m_pending_ds = 1;
                        m_mc++;
                    end else if (bad1) begin
                        m_redir = bus.s1_taken ? bus.s1_target : bus.s1_pc + 8;
                        m_pending_ds = 1;
                        m_mc++;
                    end
                end
                if (take0 && bus.s0_wr_en && bus.s0_arch_rd != 0) begin
                    m_arat[bus.s0_arch_rd] = bus.s0_phy_rd;
                    m_rel0v = 1; m_rel0r = bus.s0_old_phy_rd;
                end
                if (take1 && bus.s1_wr_en && bus.s1_arch_rd != 0) begin
                    m_arat[bus.s1_arch_rd] = bus.s1_phy_rd;
                    m_rel1v = 1; m_rel1r = bus.s1_old_phy_rd;
                end
                m_cc = m_cc + 32'(take0) + 32'(take1);
            end
            m_flush = next_flush;
        end
    end

    always @(negedge clk) begin : compare
        logic [191:0] ev;
        if (m_started) begin
            ev = '0;
            for (int i = 0; i < 32; i++) ev[i*PW +: PW] = m_arat[i];
            check("arat_snapshot", arat_snapshot, ev);
            check("fl_rel0_valid", fl_rel0_valid, m_rel0v);
            if (m_rel0v) check("fl_rel0_reg", fl_rel0_reg, m_rel0r);
            check("fl_rel1_valid", fl_rel1_valid, m_rel1v);
            if (m_rel1v) check("fl_rel1_reg", fl_rel1_reg, m_rel1r);
            check("flush_req", flush_req, m_flush);
            if (m_flush) check("redirect_pc", redirect_pc, m_redir);
            check("rob_ready", bus.rob_ready, !m_flush && !ctrl_flush);
`ifdef COMMIT_PERF_CNT_EN
            check("perf_commit_cnt", perf_commit_cnt, m_cc);
            check("perf_mispred_cnt", perf_mispred_cnt, m_mc);
`else
            check("perf_commit_cnt", perf_commit_cnt, 0);
            check("perf_mispred_cnt", perf_mispred_cnt, 0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_row();
        bus.rob_valid = 0;
        bus.s0_valid = 0; bus.s0_wr_en = 0; bus.s0_arch_rd = 0; bus.s0_phy_rd = 0;
        bus.s0_old_phy_rd = 0; bus.s0_is_br = 0; bus.s0_taken = 0; bus.s0_pred_taken = 0;
        bus.s0_target = 0; bus.s0_pred_target = 0; bus.s0_pc = 0;
        bus.s1_valid = 0; bus.s1_wr_en = 0; bus.s1_arch_rd = 0; bus.s1_phy_rd = 0;
        bus.s1_old_phy_rd = 0; bus.s1_is_br = 0; bus.s1_taken = 0; bus.s1_pred_taken = 0;
        bus.s1_target = 0; bus.s1_pred_target = 0; bus.s1_pc = 0;
    endtask

    task automatic slot0(input bit v, input bit we, input int arch, input int phy, input int old);
        bus.s0_valid = v; bus.s0_wr_en = we; bus.s0_arch_rd = 5'(arch);
        bus.s0_phy_rd = PW'(phy); bus.s0_old_phy_rd = PW'(old);
    endtask

    task automatic slot1(input bit v, input bit we, input int arch, input int phy, input int old);
        bus.s1_valid = v; bus.s1_wr_en = we; bus.s1_arch_rd = 5'(arch);
        bus.s1_phy_rd = PW'(phy); bus.s1_old_phy_rd = PW'(old);
    endtask

    task automatic br0(input logic [31:0] pc, input bit t, input bit pt,
                       input logic [31:0] tg, input logic [31:0] ptg);
        bus.s0_is_br = 1; bus.s0_pc = pc; bus.s0_taken = t; bus.s0_pred_taken = pt;
        bus.s0_target = tg; bus.s0_pred_target = ptg;
    endtask

    task automatic br1(input logic [31:0] pc, input bit t, input bit pt,
                       input logic [31:0] tg, input logic [31:0] ptg);
        bus.s1_is_br = 1; bus.s1_pc = pc; bus.s1_taken = t; bus.s1_pred_taken = pt;
        bus.s1_target = tg; bus.s1_pred_target = ptg;
    endtask

    function automatic logic [PW-1:0] arat_at(input int idx);
        return arat_snapshot[idx*PW +: PW];
    endfunction

    initial begin
        logic [31:0] cc_before;
        rst = 1; ctrl_flush = 0;
        clear_row();
        step(); step();
        rst = 0;
        check("lit_reset_arat5", arat_at(5), 5);
        check("lit_reset_arat31", arat_at(31), 31);
        check("lit_reset_flush", flush_req, 0);
        check("lit_reset_redirect", redirect_pc, 0);
        check("lit_reset_ready", bus.rob_ready, 1);

        // Same-arch pair: slot1 mapping wins, both old mappings freed.
        bus.rob_valid = 1; slot0(1, 1, 3, 40, 3); slot1(1, 1, 3, 41, 40);
        step(); clear_row();
        check("lit_samearch_arat3", arat_at(3), 41);
        check("lit_samearch_rel0", {fl_rel0_valid, fl_rel0_reg}, {1'b1, 6'd3});
        check("lit_samearch_rel1", {fl_rel1_valid, fl_rel1_reg}, {1'b1, 6'd40});

        // Slot0 mispredict with delay slot present; a row offered during flush must wait.
        bus.rob_valid = 1; slot0(1, 0, 0, 0, 0); br0(32'h100, 1, 0, 32'h200, 32'h0);
        slot1(1, 1, 5, 42, 5);
        step(); clear_row();
        check("lit_br0_flush", flush_req, 1);
        check("lit_br0_redirect", redirect_pc, 32'h200);
        check("lit_br0_ready", bus.rob_ready, 0);
        check("lit_br0_arat5", arat_at(5), 42);
        bus.rob_valid = 1; slot0(1, 1, 11, 48, 11);
        step();
        check("lit_flushcyc_arat11", arat_at(11), 11);
        check("lit_flushcyc_flush", flush_req, 0);
        step(); clear_row();
        check("lit_after_arat11", arat_at(11), 48);

        // Slot1 mispredict -> wait for delay slot; next row commits s0 only.
        bus.rob_valid = 1; slot0(1, 1, 6, 43, 6); slot1(1, 0, 0, 0, 0);
        br1(32'h104, 0, 1, 32'h0, 32'h300);
        step(); clear_row();
        check("lit_ds_wait_flush", flush_req, 0);
        bus.rob_valid = 1; slot0(1, 1, 7, 44, 7); slot1(1, 1, 8, 45, 8);
        step(); clear_row();
        check("lit_ds_arat7", arat_at(7), 44);
        check("lit_ds_arat8", arat_at(8), 8);
        check("lit_ds_rel1", fl_rel1_valid, 0);
        check("lit_ds_flush", flush_req, 1);
        check("lit_ds_redirect", redirect_pc, 32'h10C);
        step();

        // Slot0 mispredict (target only) without slot1, then ctrl_flush in WAIT_DS.
        bus.rob_valid = 1; slot0(1, 0, 0, 0, 0); br0(32'h400, 1, 1, 32'h600, 32'h500);
        step(); clear_row();
        check("lit_tgt_wait_flush", flush_req, 0);
        bus.rob_valid = 1; slot0(1, 1, 9, 46, 9); ctrl_flush = 1;
        #1 check("lit_cf_ready", bus.rob_ready, 0);
        step(); ctrl_flush = 0;
        check("lit_cf_arat9", arat_at(9), 9);
        check("lit_cf_flush", flush_req, 0);
        slot1(1, 1, 10, 47, 10);
        step(); clear_row();
        check("lit_cf_run_arat10", arat_at(10), 47);
        check("lit_cf_run_flush", flush_req, 0);

        // Arch 0 write: no map change, no release, still counts as a commit.
        cc_before = m_cc;
        bus.rob_valid = 1; slot0(1, 1, 0, 50, 0);
        step(); clear_row();
        check("lit_x0_arat0", arat_at(0), 0);
        check("lit_x0_rel0", fl_rel0_valid, 0);
`ifdef COMMIT_PERF_CNT_EN
        check("lit_x0_perf", perf_commit_cnt, cc_before + 1);
`endif

        // Lone slot1 mispredict; delay slot arrives in slot1 only.
        bus.rob_valid = 1; slot1(1, 0, 0, 0, 0); br1(32'h800, 1, 0, 32'h900, 32'h0);
        step(); clear_row();
        bus.rob_valid = 1; slot1(1, 1, 13, 55, 13);
        step(); clear_row();
        check("lit_s1ds_arat13", arat_at(13), 55);
        check("lit_s1ds_redirect", redirect_pc, 32'h900);
        step();

        // Reset wins over ctrl_flush while waiting for a delay slot.
        bus.rob_valid = 1; slot1(1, 0, 0, 0, 0); br1(32'h900, 0, 1, 32'h0, 32'hA00);
        step(); clear_row();
        rst = 1; ctrl_flush = 1;
        step();
        rst = 0; ctrl_flush = 0;
        check("lit_rst_arat6", arat_at(6), 6);
        bus.rob_valid = 1; slot0(1, 1, 14, 56, 14); slot1(1, 1, 12, 57, 12);
        step(); clear_row();
        check("lit_rst_run_arat12", arat_at(12), 57);
        check("lit_rst_run_flush", flush_req, 0);

        // A few plain directed rows, with gaps and partially valid slots.
        for (int k = 0; k < 6; k++) begin
            bus.rob_valid = (k != 2);
            slot0((k % 3) != 1, 1, 15 + k, 30 + k, 15 + k);
            slot1(k > 0, (k % 2) == 0, 20 + k, 50 + k, 20 + k);
            step();
        end
        clear_row();
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
